// File: rtl/fifo8x8_ctrl.sv
// fifo8x8_ctrl
// FIFO controller that sits directly upstream of memory8x8. It converts a push
// stream and a pop stream (both valid/ready) into single-cycle memory accesses,
// keeps wrap-around pointers and an occupancy count for the 8-entry array,
// and presents the head byte from a one-entry output register.
// Total capacity is 9 bytes: 8 in the array plus 1 in the output register.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_valid/wr_data      push request and byte (sampled on the accept edge)
//   wr_ready              push accepted this cycle (combinational)
//   rd_valid/rd_data      head byte in the output register
//   rd_ready              consumer takes rd_data
//   count                 bytes held in the array (0..8), output reg excluded
//   full, empty           count == 8, count == 0
//   mem_address/data_in   registered memory address and write data
//   mem_select/mem_rw     registered strobes, rw: 1 = read, 0 = write
//   mem_data_out          memory read data, sampled at the RD exit edge
module fifo8x8_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       rd_ready,
    output logic [3:0] count,
    output logic       full,
    output logic       empty,
    output logic [2:0] mem_address,
    output logic [7:0] mem_data_in,
    output logic       mem_select,
    output logic       mem_rw,
    input  logic [7:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t     state, state_d;
    logic [2:0] wr_ptr, wr_ptr_d;
    logic [2:0] rd_ptr, rd_ptr_d;
    logic [3:0] count_d;
    logic       rd_valid_d;
    logic [7:0] rd_data_d;
    logic [2:0] mem_address_d;
    logic [7:0] mem_data_in_d;
    logic       mem_select_d;
    logic       mem_rw_d;

    logic pop;
    logic want_rd;

    assign full  = (count == 4'd8);
    assign empty = (count == 4'd0);
    assign pop   = rd_valid & rd_ready;

    // Refilling the output register takes priority over accepting a push,
    // so the head byte appears as early as possible.
    assign want_rd  = (count != 4'd0) & (~rd_valid | rd_ready);
    assign wr_ready = (state == IDLE) & ~full & ~want_rd;

    always_comb begin
        state_d       = state;
        wr_ptr_d      = wr_ptr;
        rd_ptr_d      = rd_ptr;
        count_d       = count;
        rd_valid_d    = rd_valid & ~pop;
        rd_data_d     = rd_data;
        mem_address_d = mem_address;
        mem_data_in_d = mem_data_in;
        // Strobes fall back to "deselected read" every cycle unless an access
        // is being launched, so select is high for exactly one clock.
        mem_select_d  = 1'b0;
        mem_rw_d      = 1'b1;

        case (state)
            IDLE: begin
                if (want_rd) begin
                    state_d       = RD;
                    mem_address_d = rd_ptr;
                    mem_select_d  = 1'b1;
                    mem_rw_d      = 1'b1;
                end else if (wr_valid & ~full) begin
                    state_d       = WR;
                    mem_address_d = wr_ptr;
                    mem_data_in_d = wr_data;
                    mem_select_d  = 1'b1;
                    mem_rw_d      = 1'b0;
                end
            end
            WR: begin
                wr_ptr_d = wr_ptr + 3'd1;
                count_d  = count + 4'd1;
                state_d  = IDLE;
            end
            RD: begin
                // A refill overrides a same-edge pop: the new byte replaces
                // the old one and rd_valid stays high.
                rd_data_d  = mem_data_out;
                rd_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr + 3'd1;
                count_d    = count - 4'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Async reset also aborts any in-flight access by dropping mem_select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= 3'd0;
            rd_ptr      <= 3'd0;
            count       <= 4'd0;
            rd_valid    <= 1'b0;
            rd_data     <= 8'h00;
            mem_address <= 3'd0;
            mem_data_in <= 8'h00;
            mem_select  <= 1'b0;
            mem_rw      <= 1'b1;
        end else begin
            state       <= state_d;
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            count       <= count_d;
            rd_valid    <= rd_valid_d;
            rd_data     <= rd_data_d;
            mem_address <= mem_address_d;
            mem_data_in <= mem_data_in_d;
            mem_select  <= mem_select_d;
            mem_rw      <= mem_rw_d;
        end
    end

endmodule

// File: tb/tb_fifo8x8_ctrl.sv
// Directed testbench for fifo8x8_ctrl with a behavioural memory8x8 beside it.
module tb_fifo8x8_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready = 1'b0;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic [2:0] mem_address;
    logic [7:0] mem_data_in;
    logic       mem_select;
    logic       mem_rw;
    logic [7:0] mem_data_out;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fifo8x8_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_select   (mem_select),
        .mem_rw       (mem_rw),
        .mem_data_out (mem_data_out)
    );

    // memory8x8: synchronous write, combinational read.
    logic [7:0] mem [8];
    always @(posedge clk)
        if (mem_select && !mem_rw) mem[mem_address] <= mem_data_in;
    assign mem_data_out = mem[mem_address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive a push from a negedge and hold it until accepted; returns at the
    // negedge inside the WR cycle.
    task automatic push(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        wr_valid = 1'b1;
        wr_data  = b;
        for (int i = 0; i < 40 && !acc; i++) begin
            #1;
            if (wr_ready) acc = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("push_accept", acc, 1'b1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;

        // ---- reset values ----
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_count", count, 4'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_sel", mem_select, 1'b0);
        chk("rst_rw", mem_rw, 1'b1);
        chk("rst_addr", mem_address, 3'd0);
        chk("rst_din", mem_data_in, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_wr_ready", wr_ready, 1'b1);

        // ---- single byte, 3-cycle latency ----
        wr_valid = 1'b1; wr_data = 8'hA5; rd_ready = 1'b0;
        @(negedge clk);                      // WR cycle
        wr_valid = 1'b0;
        chk("wr_sel", mem_select, 1'b1);
        chk("wr_rw", mem_rw, 1'b0);
        chk("wr_addr", mem_address, 3'd0);
        chk("wr_din", mem_data_in, 8'hA5);
        chk("wr_busy_ready", wr_ready, 1'b0);
        @(negedge clk);                      // N+1: IDLE
        chk("n1_count", count, 4'd1);
        chk("n1_sel", mem_select, 1'b0);
        @(negedge clk);                      // N+2: RD
        chk("rd_sel", mem_select, 1'b1);
        chk("rd_rw", mem_rw, 1'b1);
        chk("rd_addr", mem_address, 3'd0);
        chk("n2_rd_valid", rd_valid, 1'b0);
        @(negedge clk);                      // N+3
        chk("n3_rd_valid", rd_valid, 1'b1);
        chk("n3_rd_data", rd_data, 8'hA5);
        chk("n3_count", count, 4'd0);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("pop_rd_valid", rd_valid, 1'b0);

        // ---- fill: 9 bytes total ----
        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
        @(negedge clk);
        chk("fill_rd_data", rd_data, 8'h10);
        chk("fill_rd_valid", rd_valid, 1'b1);
        chk("fill_count", count, 4'd8);
        chk("fill_full", full, 1'b1);
        #1 chk("fill_wr_ready", wr_ready, 1'b0);
        wr_valid = 1'b1; wr_data = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("ovf_wr_ready", wr_ready, 1'b0);
            chk("ovf_sel", mem_select, 1'b0);
        end
        wr_valid = 1'b0;
        chk("ovf_count", count, 4'd8);

        // ---- backpressure: head held, no RD launched ----
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rd_data", rd_data, 8'h10);
            chk("bp_sel", mem_select, 1'b0);
        end

        // ---- drain ----
        rd_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 9; c++) begin
            if (rd_valid) begin
                chk("drain_data", rd_data, 8'h10 + 8'(n));
                n++;
            end
            @(negedge clk);
        end
        chk("drain_n", n, 9);
        @(negedge clk);
        chk("drain_empty", empty, 1'b1);
        chk("drain_rd_valid", rd_valid, 1'b0);

        // ---- 12 more bytes through, pointers wrap ----
        fork
            begin
                for (int i = 0; i < 12; i++) push(8'h40 + 8'(i));
            end
            begin
                int m;
                m = 0;
                for (int c = 0; c < 600 && m < 12; c++) begin
                    @(negedge clk);
                    if (rd_valid) begin
                        chk("wrap_data", rd_data, 8'h40 + 8'(m));
                        m++;
                    end
                end
                chk("wrap_n", m, 12);
            end
        join
        repeat (3) @(negedge clk);
        chk("wrap_empty", empty, 1'b1);

        // ---- read priority over write ----
        rd_ready = 1'b0;
        push(8'hA1);
        push(8'hB2);
        @(negedge clk);                      // IDLE, count 1, A1 at head
        chk("pri_pre_count", count, 4'd1);
        wr_valid = 1'b1; wr_data = 8'hC3;
        #1 chk("pri_acc_c", wr_ready, 1'b1);
        @(negedge clk);                      // WR of C3
        wr_data = 8'hD4; rd_ready = 1'b1;    // A1 popped at WR exit
        @(negedge clk);
        chk("pri_rd_valid", rd_valid, 1'b0);
        chk("pri_count", count, 4'd2);
        chk("pri_wr_ready", wr_ready, 1'b0);
        rd_ready = 1'b0;
        @(negedge clk);                      // RD entered first
        chk("pri_rd_sel", mem_select, 1'b1);
        chk("pri_rd_rw", mem_rw, 1'b1);
        @(negedge clk);
        chk("pri_head", rd_data, 8'hB2);
        #1 chk("pri_acc_d", wr_ready, 1'b1);
        @(negedge clk);                      // WR of D4
        wr_valid = 1'b0;
        chk("pri_wr_sel", mem_select, 1'b1);
        chk("pri_wr_rw", mem_rw, 1'b0);
        chk("pri_wr_din", mem_data_in, 8'hD4);

        // ---- async reset mid-access ----
        rst_n = 1'b0;
        #1;
        chk("arst_sel", mem_select, 1'b0);
        chk("arst_rw", mem_rw, 1'b1);
        chk("arst_rd_valid", rd_valid, 1'b0);
        chk("arst_count", count, 4'd0);
        chk("arst_empty", empty, 1'b1);
        chk("arst_addr", mem_address, 3'd0);
        chk("arst_din", mem_data_in, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arel_wr_ready", wr_ready, 1'b1);
        chk("arel_empty", empty, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fifo8x8_ctrl.md
# fifo8x8_ctrl

FIFO controller that sits directly upstream of `memory8x8`. It turns two valid/ready byte streams (push and pop) into the memory's address/select/rw strobes, and manages wrap-around pointers, an occupancy count and a one-entry output register. Total capacity is 9 bytes: 8 in the array plus 1 in the output register.

## Interface
No parameters. Depth is 8 and width is 8, fixed by `memory8x8`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: push request.
- `wr_data` in 8: push byte; sampled on the accept edge.
- `wr_ready` out 1: push can be accepted this cycle.
- `rd_valid` out 1: `rd_data` holds a valid byte.
- `rd_data` out 8: head byte (output register).
- `rd_ready` in 1: consumer takes `rd_data`.
- `count` out 4: bytes stored in the array, 0..8. The output register is not counted.
- `full` out 1: `count == 8`.
- `empty` out 1: `count == 0`.
- `mem_address` out 3: drives `memory8x8.address`.
- `mem_data_in` out 8: drives `memory8x8.data_in`.
- `mem_select` out 1: drives `memory8x8.select`.
- `mem_rw` out 1: drives `memory8x8.rw`. 1 = read, 0 = write.
- `mem_data_out` in 8: from `memory8x8.data_out`.

## Operation
- State machine has three states: IDLE, WR, RD. At most one memory access at a time.
- Internal signals:
  - `wr_ptr`, `rd_ptr`: 3 bits each; they wrap 7→0 by natural overflow.
  - `pop` = `rd_valid & rd_ready`.
  - `want_rd` = (`count != 0`) & (`!rd_valid` | `rd_ready`).
- IDLE, checked in priority order:
  - If `want_rd`: go to RD. `mem_address` ← `rd_ptr`, `mem_rw` ← 1, `mem_select` ← 1.
  - Else if `wr_valid & !full`: go to WR. `mem_address` ← `wr_ptr`, `mem_data_in` ← `wr_data`, `mem_rw` ← 0, `mem_select` ← 1.
- `wr_ready` = IDLE & `!full` & `!want_rd`. It is combinational; there is a `rd_ready`→`wr_ready` path.
- WR (exactly 1 cycle), on exit:
  - `mem_select` ← 0, `mem_rw` ← 1.
  - `wr_ptr` ← `wr_ptr`+1, `count` ← `count`+1.
  - Go to IDLE.
- RD (exactly 1 cycle), on exit:
  - `rd_data` ← `mem_data_out`, `rd_valid` ← 1.
  - `rd_ptr` ← `rd_ptr`+1, `count` ← `count`−1.
  - `mem_select` ← 0, `mem_rw` ← 1.
  - Go to IDLE.
- Output register:
  - On `pop` without a refill on the same edge: `rd_valid` ← 0.
  - If a refill lands on the same edge as `pop`, the new byte replaces the old one and `rd_valid` stays 1.
  - While `rd_valid & !rd_ready`, `rd_data` is held stable.
- `mem_rw` idles at 1, so the array is never written outside WR.
- Simultaneous `count` increment and decrement cannot occur (single access per cycle).
- Overflow and underflow of the array are impossible by construction.
- A `wr_valid` pulse while `wr_ready` = 0 is ignored. The producer must hold `wr_valid` and `wr_data` until accepted.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - State = IDLE; `wr_ptr` = `rd_ptr` = 0; `count` = 0; `empty` = 1; `full` = 0.
  - `rd_valid` = 0, `rd_data` = 0x00.
  - `mem_select` = 0, `mem_rw` = 1, `mem_address` = 0, `mem_data_in` = 0x00.
  - `wr_ready` = 1 once `rst_n` is high.
- All `mem_*` outputs are registered, so the strobes are glitch-free.
- `mem_select` is high for exactly one full clock per access. Address and data are stable for that whole cycle.
- `mem_data_out` is sampled at the RD exit edge. This requires the memory read path to fit in one cycle.
- Push accepted at edge N:
  - WR occupies cycle N→N+1.
  - `count` increments at N+1.
  - Earliest next accept is edge N+2.
- First byte into an empty FIFO, accepted at edge N: IDLE at N+1, RD at N+2, `rd_valid` = 1 at N+3. First-byte latency is 3 cycles.
- `rst_n` low during WR or RD:
  - `mem_select` drops to 0 immediately (asynchronously); the access is aborted.
  - Array contents are treated as invalid.

## Test plan
- Reset: assert `rst_n` = 0 mid-stream → all outputs take their reset values asynchronously; after release `wr_ready` = 1 and `empty` = 1.
- Single byte: push 0xA5 at edge N with `rd_ready` = 0.
  - WR cycle shows `mem_select` = 1, `mem_rw` = 0, `mem_address` = 0, `mem_data_in` = 0xA5.
  - At N+3: `rd_valid` = 1, `rd_data` = 0xA5, `count` = 0.
- Fill: push 0x10..0x18 with `rd_ready` = 0.
  - Expect `rd_data` = 0x10, `count` = 8, `full` = 1, `wr_ready` = 0.
  - A further push of 0x99 is not accepted.
- Drain and wrap:
  - From full, hold `rd_ready` = 1 → pops deliver 0x10..0x18 in order, then `empty` = 1, `rd_valid` = 0.
  - Then push and pop 12 more bytes → `wr_ptr` and `rd_ptr` wrap 7→0 with order preserved.
- Backpressure: with `rd_valid` = 1, hold `rd_ready` = 0 for 5 cycles → `rd_data` is unchanged and no RD state is entered.
- Read priority: with `rd_valid` = 0, `count` = 2 and `wr_valid` = 1 → RD is entered first and `wr_ready` = 0 that cycle; the write is accepted in the following IDLE cycle.
